// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle MIC ALU: ctrl bit positions, shift
// encoding, controller states and the named ctrl words.
package alu_pkg;

  localparam int CTRL_F0   = 5;
  localparam int CTRL_F1   = 4;
  localparam int CTRL_ENA  = 3;
  localparam int CTRL_ENB  = 2;
  localparam int CTRL_INVA = 1;
  localparam int CTRL_INC  = 0;

  localparam int SHIFT_SLL8 = 1;
  localparam int SHIFT_SRA1 = 0;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_SRA1 = 2'b01,
    SH_SLL8 = 2'b10,
    SH_BOTH = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [5:0] CTRL_A         = 6'h18;
  localparam logic [5:0] CTRL_B         = 6'h14;
  localparam logic [5:0] CTRL_NOTA      = 6'h1A;
  localparam logic [5:0] CTRL_NOTB      = 6'h2C;
  localparam logic [5:0] CTRL_APLUSB    = 6'h3C;
  localparam logic [5:0] CTRL_APLUSBINC = 6'h3D;
  localparam logic [5:0] CTRL_INCA      = 6'h39;
  localparam logic [5:0] CTRL_INCB      = 6'h35;
  localparam logic [5:0] CTRL_BMINUSA   = 6'h3F;
  localparam logic [5:0] CTRL_DECB      = 6'h36;
  localparam logic [5:0] CTRL_MINUSA    = 6'h3B;
  localparam logic [5:0] CTRL_AANDB     = 6'h0C;
  localparam logic [5:0] CTRL_AORB      = 6'h1C;
  localparam logic [5:0] CTRL_ZERO      = 6'h10;
  localparam logic [5:0] CTRL_ONE       = 6'h31;
  localparam logic [5:0] CTRL_MINUSONE  = 6'h32;

endpackage

// File: rtl/alu_core.sv
// Combinational MIC-1 function unit followed by the SLL8/SRA1 shifter.
// The bypass input lets a precomputed value (the product) share the shifter.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       ctrl,
  input  logic [1:0]       shift,
  input  logic             bypass,
  input  logic [WIDTH-1:0] bypass_val,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  logic [WIDTH-1:0] aop;
  logic [WIDTH-1:0] bop;
  logic [WIDTH-1:0] fn;
  logic [WIDTH:0]   sum;

  always_comb begin
    aop = ctrl[CTRL_ENA] ? a : '0;
    bop = ctrl[CTRL_ENB] ? b : '0;
    if (ctrl[CTRL_INVA]) aop = ~aop;
    sum  = {1'b0, aop} + {1'b0, bop} + {{WIDTH{1'b0}}, ctrl[CTRL_INC]};
    fn   = '0;
    cout = 1'b0;
    case ({ctrl[CTRL_F0], ctrl[CTRL_F1]})
      2'b00:   fn = aop & bop;
      2'b01:   fn = aop | bop;
      2'b10:   fn = ~bop;
      default: begin
        fn   = sum[WIDTH-1:0];
        cout = sum[WIDTH];
      end
    endcase
    if (bypass) begin
      fn   = bypass_val;
      cout = 1'b0;
    end
    // Both shift bits set is a legal "no shift" encoding, same as neither.
    case (shift)
      SH_SLL8: result = {fn[WIDTH-9:0], 8'b0};
      SH_SRA1: result = {fn[WIDTH-1], fn[WIDTH-1:1]};
      default: result = fn;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle MIC ALU: one command in flight, registered result and flags.
// Define ALU_MC_MUL_EN to add the iterative shift-add unsigned multiplier.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       ctrl,
  input  logic [1:0]       shift,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             n,
  output logic             z,
  output logic             cout
);

  state_e           state;
  logic             accept;
  logic             load;
  logic             core_byp;
  logic [WIDTH-1:0] byp_val;
  logic [1:0]       core_shift;
  logic [WIDTH-1:0] core_res;
  logic             core_cout;
  logic             cout_d;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_ready && in_valid;

`ifdef ALU_MC_MUL_EN
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [1:0]         shift_q;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     psum;
  logic               in_mul;
  logic               mul_last;

  assign in_mul   = (state == ST_MUL);
  assign mul_last = in_mul && (cnt == CW'(WIDTH - 1));

  // prod low half starts as the multiplier and drains LSB first while the
  // partial sum grows into the high half.
  assign psum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_next = {psum, prod[WIDTH-1:1]};

  assign core_byp   = in_mul;
  assign byp_val    = prod_next[WIDTH-1:0];
  assign core_shift = in_mul ? shift_q : shift;
  assign load       = (accept && !mul) || mul_last;
  assign cout_d     = in_mul ? (prod_next[2*WIDTH-1:WIDTH] != '0) : core_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mcand   <= '0;
      shift_q <= '0;
      prod    <= '0;
    end else if (accept) begin
      cnt     <= '0;
      mcand   <= a;
      shift_q <= shift;
      prod    <= {{WIDTH{1'b0}}, b};
    end else if (in_mul) begin
      cnt  <= cnt + 1'b1;
      prod <= prod_next;
    end
  end
`else
  logic unused_mul;

  assign unused_mul = mul;
  assign core_byp   = 1'b0;
  assign byp_val    = '0;
  assign core_shift = shift;
  assign load       = accept;
  assign cout_d     = core_cout;
`endif

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a         (a),
    .b         (b),
    .ctrl      (ctrl),
    .shift     (core_shift),
    .bypass    (core_byp),
    .bypass_val(byp_val),
    .result    (core_res),
    .cout      (core_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
`ifdef ALU_MC_MUL_EN
            state <= mul ? ST_MUL : ST_DONE;
`else
            state <= ST_DONE;
`endif
          end
        end
`ifdef ALU_MC_MUL_EN
        ST_MUL:  if (mul_last) state <= ST_DONE;
`endif
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result and flags move only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c    <= '0;
      n    <= 1'b0;
      z    <= 1'b0;
      cout <= 1'b0;
    end else if (load) begin
      c    <= core_res;
      n    <= core_res[WIDTH-1];
      z    <= (core_res == '0);
      cout <= cout_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=16: directed vectors, randomized ops against a
// behavioural model, backpressure and mid-operation reset.
module tb_alu_mc;

  localparam int W = 16;
`ifdef ALU_MC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif
  localparam longint unsigned MODV = 64'h1 << W;
  localparam longint unsigned HALF = MODV / 2;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         inValid = 1'b0;
  logic         mulSel = 1'b0;
  logic         outReady = 1'b1;
  logic [W-1:0] opA = '0;
  logic [W-1:0] opB = '0;
  logic [5:0]   ctrlW = '0;
  logic [1:0]   shiftW = '0;
  logic         inReady;
  logic         outValid;
  logic [W-1:0] c;
  logic         n;
  logic         z;
  logic         coutW;

  int assertCount = 0;
  int failCount = 0;

  logic [5:0] named [16] = '{6'h18, 6'h14, 6'h1A, 6'h2C, 6'h3C, 6'h3D, 6'h39, 6'h35,
                             6'h3F, 6'h36, 6'h3B, 6'h0C, 6'h1C, 6'h10, 6'h31, 6'h32};

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rstN),
    .in_valid (inValid),
    .in_ready (inReady),
    .a        (opA),
    .b        (opB),
    .ctrl     (ctrlW),
    .shift    (shiftW),
    .mul      (mulSel),
    .out_valid(outValid),
    .out_ready(outReady),
    .c        (c),
    .n        (n),
    .z        (z),
    .cout     (coutW)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResult(input string tag, input logic [W-1:0] ec, input logic en, ez, ecout);
    checkOutput({tag, ".c"}, c, ec);
    checkOutput({tag, ".n"}, n, en);
    checkOutput({tag, ".z"}, z, ez);
    checkOutput({tag, ".cout"}, coutW, ecout);
  endtask

  // Behavioural model: plain integer arithmetic on the documented ALU rules.
  function automatic void refModel(input logic [W-1:0] ra, rb, input logic [5:0] rc,
                                   input logic [1:0] rs, input logic rm,
                                   output logic [W-1:0] ec, output logic en, ez, ecout);
    longint unsigned av, bv, fv, pv;
    if (rm && MUL_ON) begin
      pv = ra;
      pv = pv * rb;
      fv = pv % MODV;
      ecout = (pv >= MODV);
    end else begin
      av = rc[3] ? ra : 0;
      bv = rc[2] ? rb : 0;
      if (rc[1]) av = (MODV - 1) - av;
      case (rc[5:4])
        2'b00:   fv = av & bv;
        2'b01:   fv = av | bv;
        2'b10:   fv = (MODV - 1) - bv;
        default: fv = av + bv + rc[0];
      endcase
      ecout = (rc[5:4] == 2'b11) && (fv >= MODV);
      fv = fv % MODV;
    end
    if (rs == 2'b10) fv = (fv * 256) % MODV;
    else if (rs == 2'b01) fv = fv / 2 + ((fv >= HALF) ? HALF : 0);
    ec = fv[W-1:0];
    en = (fv >= HALF);
    ez = (fv == 0);
  endfunction

  // Called #1 after an edge with the DUT idle; returns once out_valid is seen.
  task automatic applyStimulus(input logic [W-1:0] ta, tb2, input logic [5:0] tc,
                               input logic [1:0] ts, input logic tm,
                               output int lat, output bit leak);
    opA = ta; opB = tb2; ctrlW = tc; shiftW = ts; mulSel = tm;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    lat = 1;
    leak = 1'b0;
    while (!outValid && lat < 64) begin
      leak |= inReady;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] ta, tb2, input logic [5:0] tc,
                       input logic [1:0] ts, input logic tm);
    int lat;
    bit leak;
    logic [W-1:0] ec;
    logic en, ez, ecout;
    applyStimulus(ta, tb2, tc, ts, tm, lat, leak);
    refModel(ta, tb2, tc, ts, tm, ec, en, ez, ecout);
    checkOutput({tag, ".latency"}, lat, (tm && MUL_ON) ? W + 1 : 1);
    checkOutput({tag, ".ready_low"}, leak, 0);
    checkResult(tag, ec, en, ez, ecout);
    checkOutput({tag, ".done_ready"}, inReady, 0);
    @(posedge clk); #1;
    checkOutput({tag, ".release"}, inReady, 1);
  endtask

  initial begin
    logic [W-1:0] ec, ec2;
    logic en, ez, ecout;
    int lat;
    bit leak;

    #12;
    checkOutput("reset.out_valid", outValid, 0);
    checkResult("reset", '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #3;
    rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset.in_ready", inReady, 1);

    runOp("add", 16'hCDCD, 16'hABAB, 6'h3C, 2'b00, 1'b0);
    checkResult("add_const", 16'h7978, 1'b0, 1'b0, 1'b1);
    runOp("bminusa", 16'hCDCD, 16'hABAB, 6'h3F, 2'b00, 1'b0);
    checkResult("bminusa_const", 16'hDDDE, 1'b1, 1'b0, 1'b0);
    runOp("zero", 16'hCDCD, 16'hABAB, 6'h10, 2'b00, 1'b0);
    checkResult("zero_const", 16'h0000, 1'b0, 1'b1, 1'b0);
    runOp("sll8", 16'h00FF, 16'h1234, 6'h18, 2'b10, 1'b0);
    checkResult("sll8_const", 16'hFF00, 1'b1, 1'b0, 1'b0);
    runOp("sra1", 16'h8002, 16'h1234, 6'h18, 2'b01, 1'b0);
    checkOutput("sra1_const.c", c, 16'hC001);
    runOp("noshift", 16'h8002, 16'h1234, 6'h18, 2'b11, 1'b0);
    checkOutput("noshift_const.c", c, 16'h8002);

    for (int i = 0; i < 16; i++) begin
      runOp($sformatf("named%0d", i), W'($urandom()), W'($urandom()), named[i], 2'b00, 1'b0);
      runOp($sformatf("named%0d_sh", i), W'($urandom()), W'($urandom()), named[i],
            2'($urandom_range(0, 3)), 1'b0);
    end

    runOp("mul1", 16'h0012, 16'h0034, 6'h3C, 2'b00, 1'b1);
    runOp("mul2", 16'h0100, 16'h0100, 6'h3C, 2'b00, 1'b1);
`ifdef ALU_MC_MUL_EN
    checkResult("mul2_const", 16'h0000, 1'b0, 1'b1, 1'b1);
`endif
    for (int i = 0; i < 6; i++) begin
      runOp($sformatf("mulr%0d", i), W'($urandom()), W'($urandom()), 6'($urandom()),
            2'($urandom_range(0, 3)), 1'b1);
    end

    $display("[TB] backpressure phase");
    outReady = 1'b0;
    applyStimulus(16'h1111, 16'h2222, 6'h3C, 2'b00, 1'b0, lat, leak);
    refModel(16'h1111, 16'h2222, 6'h3C, 2'b00, 1'b0, ec, en, ez, ecout);
    checkOutput("bp.latency", lat, 1);
    checkResult("bp.first", ec, en, ez, ecout);
    opA = 16'h3333; opB = 16'h4444; ctrlW = 6'h3C; shiftW = 2'b00; mulSel = 1'b0;
    inValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput("bp.hold_c", c, ec);
      checkOutput("bp.hold_cout", coutW, ecout);
      checkOutput("bp.hold_ready", inReady, 0);
      checkOutput("bp.hold_valid", outValid, 1);
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp.idle_ready", inReady, 1);
    checkOutput("bp.idle_valid", outValid, 0);
    checkOutput("bp.idle_c", c, ec);
    @(posedge clk); #1;
    inValid = 1'b0;
    refModel(16'h3333, 16'h4444, 6'h3C, 2'b00, 1'b0, ec2, en, ez, ecout);
    checkOutput("bp.second_valid", outValid, 1);
    checkResult("bp.second", ec2, en, ez, ecout);
    @(posedge clk); #1;

    $display("[TB] reset-during-operation phase");
    outReady = 1'b0;
    opA = 16'h1234; opB = 16'h1111; ctrlW = 6'h3C; shiftW = 2'b00; mulSel = 1'b1;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("rst.out_valid", outValid, 0);
    checkResult("rst", '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #3;
    rstN = 1'b1;
    outReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst.in_ready", inReady, 1);
    checkOutput("rst.idle_valid", outValid, 0);
    runOp("postreset", 16'h0F0F, 16'h00F1, 6'h3C, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
